// File: rtl/div_datapath_pkg.sv
// Shared definitions for the repeated-subtraction divider datapath.
// The state encoding is the one the iteration controller is built against.
package div_datapath_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/div_step.sv
// One subtraction step of the divider: the candidate remainder and the
// r < b compare that decides whether the step may be taken.
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] b,
    output logic [W-1:0] r_next,
    output logic         lt
);

    assign r_next = r - b;
    assign lt     = (r < b);

endmodule

// File: rtl/div_datapath.sv
// Unsigned divide-by-repeated-subtraction datapath driven by the one-hot
// iteration controller; also watches the start/do_iter/ready handshake.
module div_datapath
    import div_datapath_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         do_iter,
    input  logic         ready,
    output logic         zero,
    output logic         busy,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         res_valid,
    output logic         div_err,
    output logic         proto_err
);

    // Handshake: start is honoured only in IDLE; do_iter and ready only in
    // RUN. Anything else is a violation: it sets proto_err and is ignored.
    // In RUN, ready takes priority over do_iter.

    state_t       state;
    state_t       state_next;
    logic [W-1:0] r_reg;
    logic [W-1:0] q_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] r_sub;
    logic         r_lt;
    logic         run_zero;
    logic         load;
    logic         step;
    logic         finish;
    logic         viol;

    div_step #(.W(W)) u_step (
        .r      (r_reg),
        .b      (b_reg),
        .r_next (r_sub),
        .lt     (r_lt)
    );

    assign run_zero = r_lt | (b_reg == '0);
    assign zero     = (state == RUN) ? run_zero : 1'b1;
    assign busy     = (state == RUN);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        viol       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
                if (do_iter || ready) viol = 1'b1;
            end
            RUN: begin
                if (start) viol = 1'b1;
                if (ready) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (do_iter && !run_zero) begin
                    step = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg     <= '0;
            q_reg     <= '0;
            b_reg     <= '0;
            quotient  <= '0;
            remainder <= '0;
            res_valid <= 1'b0;
            div_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            res_valid <= finish;
            if (viol) proto_err <= 1'b1;
            if (load) begin
                r_reg   <= a;
                b_reg   <= b;
                q_reg   <= '0;
                div_err <= (b == '0);
            end else if (step) begin
                // Guarded by ~zero, so neither underflow nor quotient wrap.
                r_reg <= r_sub;
                q_reg <= q_reg + 1'b1;
            end
            if (finish) begin
                quotient  <= q_reg;
                remainder <= r_reg;
            end
        end
    end

endmodule
